// File: rtl/skew_pipe_pkg.sv
// Shared constants and depth helpers for the skewed multi-channel delay pipe.
package skew_pipe_pkg;

    localparam int unsigned DEF_D_W      = 8;
    localparam int unsigned DEF_CH       = 4;
    localparam int unsigned DEF_BASE     = 1;
    localparam int unsigned DEF_STEP     = 1;
    localparam int unsigned DEF_SKEW_DIR = 0;

    // Depth of channel i: BASE plus STEP per index, index mirrored for decreasing skew.
    function automatic int unsigned depth_of(input int unsigned i,
                                             input int unsigned ch,
                                             input int unsigned base,
                                             input int unsigned step,
                                             input int unsigned skew_dir);
        int unsigned k;
        k = (skew_dir != 0) ? (ch - 1 - i) : i;
        return base + k * step;
    endfunction

    function automatic int unsigned max_depth(input int unsigned ch,
                                              input int unsigned base,
                                              input int unsigned step);
        return base + (ch - 1) * step;
    endfunction

    localparam int unsigned MAX_DEPTH = max_depth(DEF_CH, DEF_BASE, DEF_STEP);

endpackage

// File: rtl/skew_pipe_lane.sv
// Single-channel delay line of DEPTH stages carrying a valid bit and a data word.
module skew_pipe_lane
    import skew_pipe_pkg::*;
#(
    parameter int unsigned D_W   = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [D_W-1:0] in_data,
    output logic           out_valid,
    output logic [D_W-1:0] out_data,
    output logic           busy
);

    logic [DEPTH-1:0]          v_q;
    logic [DEPTH-1:0][D_W-1:0] d_q;

    // Flush outranks enable; data moves alongside valid so bubbles keep their slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            d_q <= '0;
        end else if (flush) begin
            v_q <= '0;
            d_q <= '0;
        end else if (en) begin
            v_q[0] <= in_valid;
            d_q[0] <= in_data;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                v_q[s] <= v_q[s-1];
                d_q[s] <= d_q[s-1];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign busy      = |v_q;

endmodule

// File: rtl/skew_pipe.sv
// CH independent delay lanes with linearly skewed depths, shared enable and flush.
module skew_pipe
    import skew_pipe_pkg::*;
#(
    parameter int unsigned D_W          = DEF_D_W,
    parameter int unsigned CH           = DEF_CH,
    parameter int unsigned BASE         = DEF_BASE,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned SKEW_DIR     = DEF_SKEW_DIR,
    parameter int unsigned ZERO_INVALID = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [CH-1:0]     in_valid,
    input  logic [CH*D_W-1:0] in_data,
    output logic [CH-1:0]     out_valid,
    output logic [CH*D_W-1:0] out_data,
    output logic              busy
);

    logic [CH-1:0]          lane_v;
    logic [CH-1:0][D_W-1:0] lane_d;
    logic [CH-1:0]          lane_busy;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        localparam int unsigned DEP = depth_of(g, CH, BASE, STEP, SKEW_DIR);

        skew_pipe_lane #(
            .D_W   (D_W),
            .DEPTH (DEP)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .flush     (flush),
            .in_valid  (in_valid[g]),
            .in_data   (in_data[g*D_W +: D_W]),
            .out_valid (lane_v[g]),
            .out_data  (lane_d[g]),
            .busy      (lane_busy[g])
        );

        // Masking uses only the lane's own output registers, never an input.
        if (ZERO_INVALID != 0) begin : g_zero
            assign out_data[g*D_W +: D_W] = lane_v[g] ? lane_d[g] : '0;
        end else begin : g_raw
            assign out_data[g*D_W +: D_W] = lane_d[g];
        end
    end

    assign out_valid = lane_v;
    assign busy      = |lane_busy;

endmodule

// File: doc/skew_pipe.md
SKEW_PIPE -- requirements
Module: skew_pipe

Interface
REQ-001 Parameter D_W, default 8: data width per channel, in bits.
REQ-002 Parameter CH, default 4: number of independent channels.
REQ-003 Parameter BASE, default 1: delay of the shortest channel, in enabled cycles; legal range 1 or more.
REQ-004 Parameter STEP, default 1: extra delay per channel index step; legal range 0 or more.
REQ-005 Parameter SKEW_DIR, default 0: 0 gives increasing skew (channel 0 shortest); 1 gives decreasing skew (channel CH-1 shortest).
REQ-006 Parameter ZERO_INVALID, default 1: 1 forces the output data of a channel to 0 while that channel's output valid is low.
REQ-007 clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 en  input  1  advance enable; 0 holds every stage of every channel.
REQ-010 flush  input  1  synchronous clear of all in-flight data.
REQ-011 in_valid  input  CH  per-channel input valid.
REQ-012 in_data  input  CH*D_W  channel i occupies bits [i*D_W +: D_W].
REQ-013 out_valid  output  CH  per-channel output valid.
REQ-014 out_data  output  CH*D_W  packed the same way as in_data.
REQ-015 busy  output  1  1 while any stage of any channel holds valid data.

Function
REQ-016 Channel i SHALL have depth DEPTH(i) = BASE + k*STEP, where k = i when SKEW_DIR=0 and k = CH-1-i when SKEW_DIR=1.
REQ-017 A {valid, data} pair sampled on an edge with en=1 SHALL appear on that channel's output after exactly DEPTH(i) enabled edges; edges with en=0 do not count.
REQ-018 With en=0 and flush=0, every stage (valid and data) SHALL hold its value, and inputs SHALL be ignored.
REQ-019 With en=1, every stage SHALL shift by one, and stage 0 of each channel SHALL load that channel's in_valid and in_data.
REQ-020 Data SHALL propagate whether valid is high or low, so an invalid slot occupies a pipeline position like a bubble.
REQ-021 flush=1 SHALL clear every valid bit and every data stage to 0 on that edge, regardless of en; inputs on that edge are discarded.
REQ-022 When flush=1 and en=1 on the same edge, flush SHALL win.
REQ-023 out_valid and out_data SHALL come directly from registers, with no combinational path from any input.
REQ-024 When ZERO_INVALID=1, out_data for channel i SHALL be 0 whenever out_valid[i]=0; when ZERO_INVALID=0, the raw last-stage data SHALL be driven.
REQ-025 busy SHALL be the OR of all valid stage bits, including the output stage.
REQ-026 Channels SHALL be fully independent; only en and flush are shared.

Reset
REQ-027 rst_n low SHALL immediately clear all valid and data stages to 0: out_valid=0, out_data=0, busy=0.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight data; no value sampled before reset may reappear afterwards.
REQ-029 The first edge after rst_n deasserts SHALL behave as a normal en/flush edge.

Structure
REQ-030 The design SHALL use one sub-module, skew_pipe_lane: a single-channel delay line with parameters D_W and DEPTH, plus en, flush, valid and data ports.
REQ-031 The top level SHALL generate CH lanes, each with its DEPTH computed per REQ-016.
REQ-032 The package skew_pipe_pkg SHALL hold the depth_of(i, CH, BASE, STEP, SKEW_DIR) function and the max-depth constant used by the bench.

Verification
REQ-033 Defaults; in_valid=4'hF and channel i data = 8'h10+i for one cycle, en=1 -> ch0 emerges after 1 cycle, ch1 after 2, ch2 after 3, ch3 after 4; each channel is valid for exactly one cycle.
REQ-034 SKEW_DIR=1, same stimulus -> ch3 emerges after 1 cycle and ch0 after 4; data values are unchanged.
REQ-035 Defaults; 8'hAA injected on ch3, en dropped for 3 cycles after 2 cycles -> 8'hAA appears on the 7th edge; out_data is held stable while en=0.
REQ-036 Ch2 loaded with 8'h55, flush on the next edge with en=1 -> out_valid stays 0 forever and busy=0 one edge after flush.
REQ-037 rst_n pulsed low asynchronously while 4 values are in flight -> outputs go to 0 before the next edge; none of the 4 values ever appears.
REQ-038 ZERO_INVALID=1 with in_valid=0 and in_data=8'hFF -> out_data stays 0; with ZERO_INVALID=0 -> 8'hFF appears with out_valid=0.
